// File: rtl/hs_pkg.sv
// rtl/hs_pkg.sv - shared handshake stage mode type and capacity helper
package hs_pkg;

    // HS_FWD : one entry per stage, ready forwarded combinationally upstream
    // HS_SKID: two entries per stage (main + skid), upstream ready is a flop
    typedef enum logic {
        HS_FWD  = 1'b0,
        HS_SKID = 1'b1
    } hs_mode_e;

    // Number of payload entries a chain of `depth` stages can hold.
    function automatic int hs_cap(input int depth, input hs_mode_e mode);
        return (mode == HS_SKID) ? 2 * depth : depth;
    endfunction

endpackage

// File: rtl/hs_stage.sv
// rtl/hs_stage.sv - single valid/ready register stage, forwarded-ready or skid
//
// Ports:
//   clk, rst, flush          clock, sync active-high reset, sync clear
//   up_valid/up_ready/up_data    upstream handshake and payload
//   dn_valid/dn_ready/dn_data    downstream handshake and payload
module hs_stage
    import hs_pkg::*;
#(
    parameter int       WIDTH = 32,
    parameter hs_mode_e MODE  = HS_FWD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_data
);

    logic clr;
    logic up_fire;

    assign clr     = rst | flush;
    assign up_fire = up_valid & up_ready;

    generate
        if (MODE == HS_SKID) begin : g_skid
            logic             m_v;
            logic             s_v;
            logic [WIDTH-1:0] m_d;
            logic [WIDTH-1:0] s_d;
            logic             load_m_in;
            logic             load_s_in;
            logic             move_s;

            // Ready depends only on the skid flop, which breaks the ready path.
            assign up_ready  = ~s_v;
            // Incoming word goes straight to main when main is free or draining;
            // otherwise it parks in skid. up_fire and move_s are exclusive
            // because a full skid deasserts up_ready.
            assign load_m_in = up_fire & (~m_v | dn_ready);
            assign load_s_in = up_fire & m_v & ~dn_ready;
            assign move_s    = s_v & dn_ready;

            always_ff @(posedge clk) begin
                if (clr) begin
                    m_v <= 1'b0;
                    s_v <= 1'b0;
                end else begin
                    if (load_m_in || move_s) begin
                        m_v <= 1'b1;
                    end else if (dn_ready) begin
                        m_v <= 1'b0;
                    end
                    if (load_s_in) begin
                        s_v <= 1'b1;
                    end else if (move_s) begin
                        s_v <= 1'b0;
                    end
                end
            end

            // Payload registers carry no reset; validity lives in m_v/s_v.
            always_ff @(posedge clk) begin
                if (move_s) begin
                    m_d <= s_d;
                end else if (load_m_in) begin
                    m_d <= up_data;
                end
                if (load_s_in) begin
                    s_d <= up_data;
                end
            end

            assign dn_valid = m_v;
            assign dn_data  = m_d;
        end else begin : g_fwd
            logic             v;
            logic [WIDTH-1:0] d;

            assign up_ready = ~v | dn_ready;

            always_ff @(posedge clk) begin
                if (clr) begin
                    v <= 1'b0;
                end else if (up_fire) begin
                    v <= 1'b1;
                end else if (dn_ready) begin
                    v <= 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (up_fire) begin
                    d <= up_data;
                end
            end

            assign dn_valid = v;
            assign dn_data  = d;
        end
    endgenerate

endmodule

// File: rtl/hs_pipe.sv
// rtl/hs_pipe.sv - chain of DEPTH handshake stages with flush and occupancy
//
// Ports:
//   clk, rst, flush                 clock, sync active-high reset, sync clear
//   in_valid/in_ready/in_data       producer side
//   out_valid/out_ready/out_data    consumer side
//   occupancy                       entries currently held (0..CAP)
module hs_pipe
    import hs_pkg::*;
#(
    parameter int       WIDTH = 32,
    parameter int       DEPTH = 1,
    parameter hs_mode_e MODE  = HS_FWD,
    localparam int      CAP   = hs_cap(DEPTH, MODE),
    localparam int      OCC_W = $clog2(CAP + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    logic clr;
    logic in_fire;
    logic out_fire;

    assign clr = rst | flush;

    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            logic             s_up_valid;
            logic             s_up_ready;
            logic [WIDTH-1:0] s_up_data;
            logic             s_dn_valid;
            logic             s_dn_ready;
            logic [WIDTH-1:0] s_dn_data;

            if (k == 0) begin : g_first
                assign s_up_valid = in_valid;
                assign s_up_data  = in_data;
            end else begin : g_link
                assign s_up_valid = g_stage[k-1].s_dn_valid;
                assign s_up_data  = g_stage[k-1].s_dn_data;
            end

            if (k == DEPTH - 1) begin : g_last
                assign s_dn_ready = out_ready;
            end else begin : g_mid
                assign s_dn_ready = g_stage[k+1].s_up_ready;
            end

            hs_stage #(
                .WIDTH (WIDTH),
                .MODE  (MODE)
            ) u_stage (
                .clk      (clk),
                .rst      (rst),
                .flush    (flush),
                .up_valid (s_up_valid),
                .up_ready (s_up_ready),
                .up_data  (s_up_data),
                .dn_valid (s_dn_valid),
                .dn_ready (s_dn_ready),
                .dn_data  (s_dn_data)
            );
        end
    endgenerate

    // Both ports are closed while clearing so nothing can transfer in that
    // cycle; internal stage moves are discarded by the stage clear anyway.
    assign in_ready  = g_stage[0].s_up_ready & ~clr;
    assign out_valid = g_stage[DEPTH-1].s_dn_valid & ~clr;
    assign out_data  = g_stage[DEPTH-1].s_dn_data;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (clr) begin
            occupancy <= '0;
        end else if (in_fire && !out_fire) begin
            occupancy <= occupancy + OCC_W'(1);
        end else if (!in_fire && out_fire) begin
            occupancy <= occupancy - OCC_W'(1);
        end
    end

endmodule

// File: tb/tb_hs_pipe.sv
// tb/tb_hs_pipe.sv - self-checking bench for hs_pipe across depths and modes
module tb_hs_pipe;
    import hs_pkg::*;

    localparam int NI = 6;

    // inst: 0 D3 FWD, 1 D3 SKID, 2 D2 SKID, 3 D2 FWD, 4 D4 FWD, 5 D4 SKID
    function automatic int dep_of(input int i);
        case (i)
            0, 1:    return 3;
            2, 3:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic hs_mode_e mode_of(input int i);
        return (i == 1 || i == 2 || i == 5) ? HS_SKID : HS_FWD;
    endfunction

    logic        clk;
    logic        rst;
    logic        iv   [NI];
    logic [31:0] id   [NI];
    logic        ordy [NI];
    logic        fl   [NI];
    logic        ir   [NI];
    logic        ov   [NI];
    logic [31:0] od   [NI];
    logic [7:0]  occ  [NI];

    int checks;
    int errors;
    int cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input int n,
                                input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s inst%0d got %0h want %0h", nm, n, got, exp);
        end
    endfunction

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            localparam int       D = dep_of(g);
            localparam hs_mode_e M = mode_of(g);
            localparam int       C = hs_cap(D, M);

            logic [$clog2(C+1)-1:0] occ_l;
            logic [31:0]            q [$];
            int                     qt [$];
            logic                   hold_prev;
            logic [31:0]            data_prev;

            hs_pipe #(
                .WIDTH (32),
                .DEPTH (D),
                .MODE  (M)
            ) u_dut (
                .clk       (clk),
                .rst       (rst),
                .flush     (fl[g]),
                .in_valid  (iv[g]),
                .in_ready  (ir[g]),
                .in_data   (id[g]),
                .out_valid (ov[g]),
                .out_ready (ordy[g]),
                .out_data  (od[g]),
                .occupancy (occ_l)
            );

            assign occ[g] = 8'(occ_l);

            // Model: FIFO of accepted words with their acceptance cycle. The
            // oldest word can never be blocked by younger ones, so it reaches
            // the output exactly D cycles after entry and waits there.
            always @(negedge clk) begin
                if (rst || fl[g]) begin
                    chk("clr_in_ready", g, 32'(ir[g]), 32'd0);
                    chk("clr_out_valid", g, 32'(ov[g]), 32'd0);
                    q.delete();
                    qt.delete();
                end else begin
                    chk("occupancy", g, 32'(occ[g]), q.size());
                    chk("out_valid", g, 32'(ov[g]),
                        32'(q.size() > 0 && (cyc - qt[0]) >= D));
                    if (ov[g] && q.size() > 0)
                        chk("out_data", g, od[g], q[0]);
                    if (M == HS_FWD)
                        chk("in_ready_fwd", g, 32'(ir[g]),
                            32'((q.size() < C) || ordy[g]));
                    else if (q.size() == 0)
                        chk("in_ready_empty", g, 32'(ir[g]), 32'd1);
                    else if (q.size() == C)
                        chk("in_ready_full", g, 32'(ir[g]), 32'd0);
                    if (hold_prev && iv[g])
                        chk("producer_hold", g, id[g], data_prev);
                    if (ov[g] && ordy[g] && q.size() > 0) begin
                        void'(q.pop_front());
                        void'(qt.pop_front());
                    end
                    if (iv[g] && ir[g]) begin
                        q.push_back(id[g]);
                        qt.push_back(cyc);
                    end
                end
                hold_prev <= iv[g] & ~ir[g] & ~(rst | fl[g]);
                data_prev <= id[g];
            end
        end
    endgenerate

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_stream(input int n);
        int nout;
        nout    = 0;
        ordy[n] = 1'b1;
        for (int t = 0; t < 24; t++) begin
            iv[n] = (t < 16);
            id[n] = 32'(t + 1);
            @(negedge clk);
            if (t < 16) chk("stream_in_ready", n, 32'(ir[n]), 32'd1);
            chk("stream_out_valid", n, 32'(ov[n]), 32'(t >= 3 && t < 19));
            if (ov[n]) begin
                chk("stream_data", n, od[n], 32'(t - 2));
                nout++;
            end
            if (t >= 3 && t <= 16) chk("stream_occ", n, 32'(occ[n]), 32'd3);
            next_cycle();
        end
        chk("stream_count", n, 32'(nout), 32'd16);
        iv[n]   = 1'b0;
        ordy[n] = 1'b0;
    endtask

    task automatic run_fill(input int n);
        logic [31:0] w [5];
        int k;
        int nrecv;
        w = '{32'hA, 32'hB, 32'hC, 32'hD, 32'hE};
        k = 0;
        nrecv = 0;
        ordy[n] = 1'b0;
        for (int t = 0; t < 8; t++) begin
            iv[n] = 1'b1;
            id[n] = w[k];
            @(negedge clk);
            chk("fill_in_ready", n, 32'(ir[n]), 32'(t < 4));
            if (ir[n]) k++;
            next_cycle();
        end
        chk("fill_accepted", n, 32'(k), 32'd4);
        id[n] = w[k];
        @(negedge clk);
        chk("fill_occ", n, 32'(occ[n]), 32'd4);
        chk("fill_head_valid", n, 32'(ov[n]), 32'd1);
        chk("fill_head_data", n, od[n], 32'hA);
        next_cycle();
        ordy[n] = 1'b1;
        for (int t = 0; t < 20 && nrecv < 5; t++) begin
            iv[n] = (k < 5);
            if (k < 5) id[n] = w[k];
            @(negedge clk);
            if (iv[n] && ir[n]) k++;
            if (ov[n]) begin
                chk("fill_drain_data", n, od[n], w[nrecv]);
                nrecv++;
            end
            next_cycle();
        end
        chk("fill_drain_count", n, 32'(nrecv), 32'd5);
        chk("fill_total_accepted", n, 32'(k), 32'd5);
        iv[n]   = 1'b0;
        ordy[n] = 1'b0;
    endtask

    task automatic run_flush(input int n);
        ordy[n] = 1'b0;
        iv[n]   = 1'b1;
        id[n]   = 32'h55;
        @(negedge clk);
        chk("flush_acc55", n, 32'(ir[n]), 32'd1);
        next_cycle();
        id[n] = 32'h66;
        @(negedge clk);
        chk("flush_acc66", n, 32'(ir[n]), 32'd1);
        chk("flush_occ1", n, 32'(occ[n]), 32'd1);
        next_cycle();
        id[n] = 32'h77;
        @(negedge clk);
        chk("flush_full_block", n, 32'(ir[n]), 32'd0);
        chk("flush_full_occ", n, 32'(occ[n]), 32'd2);
        next_cycle();
        fl[n] = 1'b1;
        @(negedge clk);
        chk("flush_cyc_in_ready", n, 32'(ir[n]), 32'd0);
        chk("flush_cyc_out_valid", n, 32'(ov[n]), 32'd0);
        next_cycle();
        fl[n] = 1'b0;
        @(negedge clk);
        chk("post_flush_out_valid", n, 32'(ov[n]), 32'd0);
        chk("post_flush_occ", n, 32'(occ[n]), 32'd0);
        chk("post_flush_in_ready", n, 32'(ir[n]), 32'd1);
        next_cycle();
        iv[n]   = 1'b0;
        ordy[n] = 1'b1;
        @(negedge clk);
        chk("x77_lat1", n, 32'(ov[n]), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("x77_lat2", n, 32'(ov[n]), 32'd1);
        chk("x77_data", n, od[n], 32'h77);
        next_cycle();
        @(negedge clk);
        chk("x77_gone", n, 32'(ov[n]), 32'd0);
        next_cycle();
        ordy[n] = 1'b0;
    endtask

    task automatic run_random(input int n, input int ncyc);
        int   sent;
        int   recv;
        logic fired;
        sent = 0;
        recv = 0;
        iv[n] = 1'b0;
        for (int t = 0; t < ncyc; t++) begin
            if (!iv[n] && $urandom_range(9) < 7) begin
                iv[n] = 1'b1;
                id[n] = $urandom;
            end
            ordy[n] = ($urandom_range(9) < 6);
            @(negedge clk);
            fired = iv[n] & ir[n];
            if (fired) sent++;
            if (ov[n] && ordy[n]) recv++;
            next_cycle();
            if (fired) iv[n] = 1'b0;
        end
        iv[n]   = 1'b0;
        ordy[n] = 1'b1;
        for (int t = 0; t < 40 && recv != sent; t++) begin
            @(negedge clk);
            if (ov[n]) recv++;
            next_cycle();
        end
        chk("rand_no_loss", n, 32'(recv), 32'(sent));
        @(negedge clk);
        chk("rand_end_occ", n, 32'(occ[n]), 32'd0);
        chk("rand_end_valid", n, 32'(ov[n]), 32'd0);
        next_cycle();
        ordy[n] = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst    = 1'b1;
        for (int i = 0; i < NI; i++) begin
            iv[i]   = 1'b0;
            id[i]   = '0;
            ordy[i] = 1'b0;
            fl[i]   = 1'b0;
        end
        iv[0] = 1'b1;
        next_cycle();
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            chk("rst_in_ready", 0, 32'(ir[0]), 32'd0);
            chk("rst_out_valid", 0, 32'(ov[0]), 32'd0);
            if (t < 2) next_cycle();
        end
        next_cycle();
        rst   = 1'b0;
        iv[0] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("rel_in_ready", i, 32'(ir[i]), 32'd1);
            chk("rel_out_valid", i, 32'(ov[i]), 32'd0);
            chk("rel_occ", i, 32'(occ[i]), 32'd0);
        end
        next_cycle();

        run_stream(0);
        run_stream(1);
        run_fill(2);
        run_flush(3);
        fork
            run_random(4, 10000);
            run_random(5, 10000);
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog time limit reached at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
